// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// dmem_responder_pkg : shared constants, request/response wires and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package constants;
    localparam int dmem_depth_log2 = 10;
    localparam int dmem_latency    = 1;
endpackage

package wires;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef logic [1:0] dmem_state_type;
    localparam dmem_state_type IDLE = 2'd0;
    localparam dmem_state_type BUSY = 2'd1;
    localparam dmem_state_type RESP = 2'd2;

    typedef struct packed {
        dmem_state_type state;
        logic [3:0]     cnt;
        logic [31:0]    addr;
        logic           wr;
        logic           rd_ok;
    } dmem_responder_reg_type;

    localparam dmem_responder_reg_type init_dmem_responder_reg = '{
        state : IDLE,
        cnt   : 4'd0,
        addr  : 32'd0,
        wr    : 1'b0,
        rd_ok : 1'b0
    };
endpackage

package dmem_responder_pkg;
    // Compares only the bits above the array window; base is window-aligned.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          depth_log2);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (depth_log2 + 2);
        return (addr & mask) == (base & mask);
    endfunction
endpackage

`default_nettype wire

// File: rtl/dmem_responder_sram_1rw.sv
// ============================================================================
// sram_1rw : single-port word array, 4 byte-write enables, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_1rw #(
    parameter int addr_w = 10
) (
    input  logic              clk,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [addr_w-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // One byte-wide array per lane so each lane has a single writer.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic [7:0] lane_mem [0:(1<<addr_w)-1];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (we[i]) begin
                    lane_mem[addr] <= wdata[8*i +: 8];
                end
                if (re) begin
                    lane_q <= lane_mem[addr];
                end
            end

            assign rdata[8*i +: 8] = lane_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : tightly-coupled data memory behind the core's dmem port
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder
    import wires::*;
    import dmem_responder_pkg::*;
#(
    parameter int          depth_log2 = constants::dmem_depth_log2,
    parameter int          latency    = constants::dmem_latency,
    parameter logic [31:0] base_addr  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out
);

    dmem_responder_reg_type r;
    dmem_responder_reg_type rin;

    logic                  sram_re;
    logic [3:0]            sram_we;
    logic [depth_log2-1:0] sram_addr;
    logic [31:0]           sram_q;
    logic                  in_range;

    assign in_range = addr_in_range(dmem_in.mem_addr, base_addr, depth_log2);

    always_comb begin
        dmem_responder_reg_type v;
        v         = r;
        sram_re   = 1'b0;
        sram_we   = 4'h0;
        sram_addr = r.addr[depth_log2+1:2];

        case (r.state)
            IDLE: begin
                if (dmem_in.mem_valid) begin
                    // Stores commit on the acceptance edge itself.
                    v.addr    = dmem_in.mem_addr;
                    v.wr      = (dmem_in.mem_wstrb != 4'h0) && !dmem_in.mem_instr;
                    v.rd_ok   = in_range && !v.wr;
                    v.cnt     = 4'(latency - 1);
                    v.state   = (latency == 1) ? RESP : BUSY;
                    sram_addr = dmem_in.mem_addr[depth_log2+1:2];
                    sram_we   = (in_range && !dmem_in.mem_instr) ? dmem_in.mem_wstrb : 4'h0;
                    sram_re   = (latency == 1);
                end
            end
            BUSY: begin
                v.cnt = r.cnt - 4'd1;
                if (r.cnt == 4'd1) begin
                    v.state = RESP;
                    sram_re = 1'b1;
                end
            end
            RESP: begin
                v.state = IDLE;
            end
            default: begin
                v.state = IDLE;
            end
        endcase

        if (!rst) begin
            v       = init_dmem_responder_reg;
            sram_we = 4'h0;
            sram_re = 1'b0;
        end

        rin = v;
    end

    always_ff @(posedge clk) begin
        r <= rin;
    end

    sram_1rw #(
        .addr_w (depth_log2)
    ) u_sram (
        .clk   (clk),
        .re    (sram_re),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (dmem_in.mem_wdata),
        .rdata (sram_q)
    );

    // Outputs depend only on flops; data is forced to zero outside RESP.
    always_comb begin
        dmem_out.mem_ready = (r.state == RESP);
        dmem_out.mem_rdata = ((r.state == RESP) && r.rd_ok) ? sram_q : 32'h0;
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed + random checks of two responder instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;
    import wires::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mem_in_type  din1 = '0;
    mem_in_type  din4 = '0;
    mem_out_type dout1;
    mem_out_type dout4;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [2][16];
    bit          b2b [2];

    always #5 clk = ~clk;

    dmem_responder #(.depth_log2(10), .latency(1), .base_addr(32'h0)) u_lat1 (
        .clk(clk), .rst(rst), .dmem_in(din1), .dmem_out(dout1));

    dmem_responder #(.depth_log2(10), .latency(4), .base_addr(32'h0)) u_lat4 (
        .clk(clk), .rst(rst), .dmem_in(din4), .dmem_out(dout4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int w);
        return (w == 0) ? dout1.mem_ready : dout4.mem_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int w);
        return (w == 0) ? dout1.mem_rdata : dout4.mem_rdata;
    endfunction

    task automatic set_req(input int w, input mem_in_type req);
        if (w == 0) din1 = req;
        else        din4 = req;
    endtask

    task automatic idle(input int n);
        din1.mem_valid = 1'b0;
        din4.mem_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        if (n > 0) begin
            b2b[0] = 1'b0;
            b2b[1] = 1'b0;
        end
    endtask

    // One full request/response handshake checked against the word model.
    task automatic txn(input int w, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input string tag);
        mem_in_type  req;
        int          lat_exp;
        int          cyc;
        bit          got;
        bit          is_wr;
        bit          inr;
        logic [31:0] exp_rd;
        logic [3:0]  idx;

        req.mem_valid = 1'b1;
        req.mem_instr = instr;
        req.mem_addr  = addr;
        req.mem_wdata = wdata;
        req.mem_wstrb = wstrb;
        set_req(w, req);

        lat_exp = ((w == 0) ? 1 : 4) + (b2b[w] ? 1 : 0);
        inr     = (addr - 32'h0) < 32'h1000;
        is_wr   = (wstrb != 4'h0) && !instr;
        idx     = addr[5:2];
        exp_rd  = (is_wr || !inr) ? 32'h0 : model[w][idx];
        if (inr && !instr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) model[w][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end

        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (get_ready(w)) got = 1'b1;
            else check({tag, " idle_rdata"}, get_rdata(w), 32'h0);
        end
        check({tag, " latency"}, cyc, lat_exp);
        check({tag, " rdata"}, get_rdata(w), exp_rd);

        req.mem_valid = 1'b0;
        set_req(w, req);
        b2b[w]     = 1'b1;
        b2b[1 - w] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          op;

        b2b[0] = 1'b0;
        b2b[1] = 1'b0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready1", dout1.mem_ready, 1'b0);
        check("reset rdata1", dout1.mem_rdata, 32'h0);
        check("reset ready4", dout4.mem_ready, 1'b0);
        check("reset rdata4", dout4.mem_rdata, 32'h0);
        check("reset state4", u_lat4.r.state, 2'd0);
        rst = 1'b1;
        idle(1);

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                txn(w, 1'b0, 32'(i * 4), $urandom(), 4'hF, "init");
            end
        end
        idle(2);

        txn(0, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, "l1 store");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "l1 load");
        check("l1 load value", model[0][4], 32'hDEAD_BEEF);
        txn(0, 1'b0, 32'h10, 32'h0000_AA00, 4'b0010, "strobe store");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "strobe load");
        check("strobe value", model[0][4], 32'hDEAD_AAEF);

        txn(0, 1'b0, 32'h1000, 32'h1234_5678, 4'hF, "oor store");
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, "alias load");
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, "oor load");

        txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, "fetch qual");
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "fetch after");

        idle(3);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "l4 load");
        txn(1, 1'b0, 32'h14, 32'h0, 4'h0, "l4 b2b load");
        idle(2);

        // Reset two cycles after a load is accepted on the latency-4 instance.
        din4.mem_valid = 1'b1;
        din4.mem_instr = 1'b0;
        din4.mem_addr  = 32'h10;
        din4.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("rst busy ready", dout4.mem_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        din4.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst state idle", u_lat4.r.state, 2'd0);
        check("rst ready", dout4.mem_ready, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rst no pulse", dout4.mem_ready, 1'b0);
        end
        b2b[0] = 1'b0;
        b2b[1] = 1'b0;
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, "post rst load");

        // Store presented while reset is held on its acceptance edge.
        idle(1);
        din1.mem_valid = 1'b1;
        din1.mem_instr = 1'b0;
        din1.mem_addr  = 32'h8;
        din1.mem_wdata = ~model[0][2];
        din1.mem_wstrb = 4'hF;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        din1.mem_valid = 1'b0;
        check("rst accept ready", dout1.mem_ready, 1'b0);
        idle(2);
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, "rst accept load");

        for (int n = 0; n < 60; n++) begin
            int w;
            w  = n % 2;
            op = $urandom_range(0, 9);
            d  = $urandom();
            s  = 4'($urandom_range(1, 15));
            a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if (op <= 4) begin
                txn(w, ($urandom_range(0, 7) == 0), a, d, s, "rnd store");
            end else if (op <= 7) begin
                txn(w, 1'b0, a, d, 4'h0, "rnd load");
            end else if (op == 8) begin
                a = $urandom() | 32'h1000;
                txn(w, 1'b0, a, d, ($urandom_range(0, 1) == 0) ? 4'h0 : s, "rnd oor");
            end else begin
                idle($urandom_range(0, 2));
            end
        end

        for (int i = 0; i < 16; i++) begin
            txn(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, "final1");
            txn(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, "final4");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
